set_ctrl: RTL and testbench

SET_CTRL -- requirements
Module: set_ctrl

---
 rtl/set_ctrl_if.sv | 25 ++
 rtl/set_ctrl.sv | 170 +++++++++++++++++
 tb/tb_set_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/set_ctrl_if.sv
// Button inputs and display/counter control outputs of the time-setting controller.
// master = the side that owns the buttons (board/bench); slave = set_ctrl itself.
interface set_ctrl_if;
   logic       i_sw_mode;
   logic       i_sw_pos;
   logic       i_sw_inc;
   logic [1:0] o_setting_mode;
   logic [1:0] o_setting_position;
   logic       o_blink;
   logic       o_inc_sec;
   logic       o_inc_min;
   logic       o_inc_hour;

   modport master (
      output i_sw_mode, i_sw_pos, i_sw_inc,
      input  o_setting_mode, o_setting_position, o_blink,
      input  o_inc_sec, o_inc_min, o_inc_hour
   );

   modport slave (
      input  i_sw_mode, i_sw_pos, i_sw_inc,
      output o_setting_mode, o_setting_position, o_blink,
      output o_inc_sec, o_inc_min, o_inc_hour
   );
endinterface

// File: rtl/set_ctrl.sv
// set_ctrl: clock/alarm setting controller. Three raw buttons are synchronized and
// debounced into one-cycle press events that drive a CLOCK/SET_TIME/SET_ALARM FSM
// with digit-position select, increment pulses, blink phase and idle timeout.

// Per-button front end: 2-flop synchronizer, level debouncer, rising-edge press.
module set_ctrl_deb #(
   parameter logic [19:0] DEB_CNT = 20'd500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_press
);
   localparam int DW = (DEB_CNT > 20'd1) ? $clog2(DEB_CNT) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 20'd1);

   logic [1:0]    sync_q;
   logic          deb_q;
   logic          deb_d1;
   logic [DW-1:0] cnt_q;

   // Bring the asynchronous button level into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], i_raw};
   end

   // Accept a new level only after it has differed from the debounced one for DEB_CNT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else if (sync_q[1] == deb_q) begin
         cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
         deb_q <= sync_q[1];
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + DW'(1);
      end
   end

   // Delayed debounced level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) deb_d1 <= 1'b0;
      else        deb_d1 <= deb_q;
   end

   // Only the debounced 0->1 transition is an event; releases are silent.
   assign o_press = deb_q & ~deb_d1;
endmodule

module set_ctrl #(
   parameter logic [19:0] DEB_CNT    = 20'd500000,
   parameter logic [31:0] BLINK_HALF = 32'd25000000,
   parameter logic [31:0] TIMEOUT    = 32'd500000000
) (
   input  logic       clk,
   input  logic       rst_n,
   set_ctrl_if.slave  bus
);
   localparam int NUM_BTN  = 3;
   localparam int BTN_MODE = 0;
   localparam int BTN_POS  = 1;
   localparam int BTN_INC  = 2;

   localparam int BW = (BLINK_HALF > 32'd1) ? $clog2(BLINK_HALF) : 1;
   localparam int TW = (TIMEOUT    > 32'd1) ? $clog2(TIMEOUT)    : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 32'd1);
   localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 32'd1);

   typedef enum logic [1:0] {
      CLOCK     = 2'd0,
      SET_TIME  = 2'd1,
      SET_ALARM = 2'd2
   } mode_e;

   // Everything the FSM carries from cycle to cycle; inc is {hour, min, sec}.
   typedef struct packed {
      mode_e         state;
      logic [1:0]    pos;
      logic          blink;
      logic [2:0]    inc;
      logic [BW-1:0] blink_cnt;
      logic [TW-1:0] idle_cnt;
   } ctrl_t;

   ctrl_t               cur_q;
   ctrl_t               nxt;
   logic [NUM_BTN-1:0]  raw;
   logic [NUM_BTN-1:0]  press;

   assign raw = {bus.i_sw_inc, bus.i_sw_pos, bus.i_sw_mode};

   generate
      for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
         set_ctrl_deb #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (raw[g]),
            .o_press (press[g])
         );
      end
   endgenerate

   // FSM state, outputs and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur_q <= '0;
      else        cur_q <= nxt;
   end

   // Next state: mode beats position beats inc beats timeout; losing events are dropped.
   always_comb begin
      nxt     = cur_q;
      nxt.inc = 3'b000;
      if (press[BTN_MODE]) begin
         case (cur_q.state)
            CLOCK:    nxt.state = SET_TIME;
            SET_TIME: nxt.state = SET_ALARM;
            default:  nxt.state = CLOCK;
         endcase
         nxt.pos       = 2'd0;
         nxt.blink     = 1'b0;
         nxt.blink_cnt = '0;
         nxt.idle_cnt  = '0;
      end else if (cur_q.state == CLOCK) begin
         // Position/inc are ignored here and the timers stay parked at zero.
         nxt.pos       = 2'd0;
         nxt.blink     = 1'b0;
         nxt.blink_cnt = '0;
         nxt.idle_cnt  = '0;
      end else if (press[BTN_POS]) begin
         nxt.pos       = (cur_q.pos == 2'd2) ? 2'd0 : cur_q.pos + 2'd1;
         nxt.blink     = 1'b0;
         nxt.blink_cnt = '0;
         nxt.idle_cnt  = '0;
      end else if (press[BTN_INC]) begin
         case (cur_q.pos)
            2'd0:    nxt.inc = 3'b001;
            2'd1:    nxt.inc = 3'b010;
            default: nxt.inc = 3'b100;
         endcase
         // Keep the digit lit while the user is adjusting it.
         nxt.blink     = 1'b0;
         nxt.blink_cnt = '0;
         nxt.idle_cnt  = '0;
      end else if (cur_q.idle_cnt == IDLE_LAST) begin
         nxt.state     = CLOCK;
         nxt.pos       = 2'd0;
         nxt.blink     = 1'b0;
         nxt.blink_cnt = '0;
         nxt.idle_cnt  = '0;
      end else begin
         nxt.idle_cnt = cur_q.idle_cnt + TW'(1);
         if (cur_q.blink_cnt == BLINK_LAST) begin
            nxt.blink_cnt = '0;
            nxt.blink     = ~cur_q.blink;
         end else begin
            nxt.blink_cnt = cur_q.blink_cnt + BW'(1);
         end
      end
   end

   assign bus.o_setting_mode     = cur_q.state;
   assign bus.o_setting_position = cur_q.pos;
   assign bus.o_blink            = cur_q.blink;
   assign bus.o_inc_sec          = cur_q.inc[0];
   assign bus.o_inc_min          = cur_q.inc[1];
   assign bus.o_inc_hour         = cur_q.inc[2];
endmodule

// File: tb/tb_set_ctrl.sv
// Bench for set_ctrl with DEB_CNT=4, BLINK_HALF=8, TIMEOUT=64. Stimulus pushes
// every expected output change (cycle stamp + value) into a queue; the monitor
// pops on each observed change. Output word = {mode[1:0], pos[1:0], blink, hour, min, sec}.
module tb_set_ctrl;
   logic clk = 1'b0;
   logic rst_n;

   set_ctrl_if bus ();

   set_ctrl #(
      .DEB_CNT    (20'd4),
      .BLINK_HALF (32'd8),
      .TIMEOUT    (32'd64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] obs();
      return {bus.o_setting_mode, bus.o_setting_position, bus.o_blink,
              bus.o_inc_hour, bus.o_inc_min, bus.o_inc_sec};
   endfunction

   function automatic logic [7:0] pk(input logic [1:0] m, input logic [1:0] p,
                                     input logic b, input logic [2:0] i);
      return {m, p, b, i};
   endfunction

   function automatic void push(input int c, input logic [7:0] v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // mask bit0=mode, bit1=pos, bit2=inc; raw held for 'hold' sampling edges
   task automatic press(input logic [2:0] mask, input int hold);
      bus.i_sw_mode = mask[0];
      bus.i_sw_pos  = mask[1];
      bus.i_sw_inc  = mask[2];
      repeat (hold) @(negedge clk);
      bus.i_sw_mode = 1'b0;
      bus.i_sw_pos  = 1'b0;
      bus.i_sw_inc  = 1'b0;
   endtask

   task automatic do_reset(input logic hold_mode);
      rst_n = 1'b0;
      #1;
      chk("async_reset", obs(), 8'h00);
      bus.i_sw_mode = hold_mode;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compares every output change against the head of the queue.
   initial begin
      logic [7:0] prev;
      logic [7:0] cur;
      exp_t       e;
      prev = 8'h00;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         cur = obs();
         while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: nothing seen at cycle %0d, required %h", q[0].cyc, q[0].val);
            void'(q.pop_front());
         end
         if (cur != prev) begin
            checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
               errors++;
               $display("FAIL unexpected_change at cycle %0d: got %h, required %h", cyc, cur, prev);
            end else begin
               e = q.pop_front();
               if (cur !== e.val) begin
                  errors++;
                  $display("FAIL output_value at cycle %0d: got %h, required %h", cyc, cur, e.val);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: stimulus did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.i_sw_mode = 1'b0;
      bus.i_sw_pos  = 1'b0;
      bus.i_sw_inc  = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_state", obs(), 8'h00);
      @(negedge clk);

      // Long mode pulse enters SET_TIME on the 7th edge; a 3-cycle glitch is ignored.
      base = cyc;
      push(base + 7,  pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 15, pk(2'd1, 2'd0, 1'b1, 3'b000));
      push(base + 23, pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 27, 8'h00);
      press(3'b001, 10);
      wait_until(base + 20); press(3'b001, 3);
      wait_until(base + 26); do_reset(1'b0);
      @(negedge clk);

      // Position walk 1,2 then inc at hour, then position wraps to 0.
      base = cyc;
      push(base + 7,  pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 15, pk(2'd1, 2'd0, 1'b1, 3'b000));
      push(base + 21, pk(2'd1, 2'd1, 1'b0, 3'b000));
      push(base + 29, pk(2'd1, 2'd1, 1'b1, 3'b000));
      push(base + 35, pk(2'd1, 2'd2, 1'b0, 3'b000));
      push(base + 43, pk(2'd1, 2'd2, 1'b1, 3'b000));
      push(base + 49, pk(2'd1, 2'd2, 1'b0, 3'b100));
      push(base + 50, pk(2'd1, 2'd2, 1'b0, 3'b000));
      push(base + 57, pk(2'd1, 2'd2, 1'b1, 3'b000));
      push(base + 63, pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 67, 8'h00);
      press(3'b001, 5);
      wait_until(base + 14); press(3'b010, 5);
      wait_until(base + 28); press(3'b010, 5);
      wait_until(base + 42); press(3'b100, 5);
      wait_until(base + 56); press(3'b010, 5);
      wait_until(base + 66); do_reset(1'b0);
      @(negedge clk);

      // Blink cadence, inc restarts it, then 64 idle cycles fall back to CLOCK.
      base = cyc;
      push(base + 7,  pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 15, pk(2'd1, 2'd0, 1'b1, 3'b000));
      push(base + 23, pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 31, pk(2'd1, 2'd0, 1'b1, 3'b000));
      push(base + 33, pk(2'd1, 2'd0, 1'b0, 3'b001));
      push(base + 34, pk(2'd1, 2'd0, 1'b0, 3'b000));
      for (int k = 0; k < 7; k++)
         push(base + 41 + 8 * k, pk(2'd1, 2'd0, (k % 2 == 0) ? 1'b1 : 1'b0, 3'b000));
      push(base + 97, 8'h00);
      press(3'b001, 5);
      wait_until(base + 26); press(3'b100, 5);
      wait_until(base + 110);

      // Same-cycle events: mode beats pos, pos beats inc.
      base = cyc;
      push(base + 7,  pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 15, pk(2'd1, 2'd0, 1'b1, 3'b000));
      push(base + 21, pk(2'd1, 2'd1, 1'b0, 3'b000));
      push(base + 29, pk(2'd1, 2'd1, 1'b1, 3'b000));
      push(base + 35, pk(2'd2, 2'd0, 1'b0, 3'b000));
      push(base + 43, pk(2'd2, 2'd0, 1'b1, 3'b000));
      push(base + 49, pk(2'd2, 2'd1, 1'b0, 3'b000));
      push(base + 57, pk(2'd2, 2'd1, 1'b1, 3'b000));
      push(base + 63, 8'h00);
      press(3'b001, 5);
      wait_until(base + 14); press(3'b010, 5);
      wait_until(base + 28); press(3'b011, 5);
      wait_until(base + 42); press(3'b110, 5);
      wait_until(base + 56); press(3'b001, 5);
      wait_until(base + 70);

      // CLOCK ignores pos/inc; reach SET_ALARM pos 2, then async reset with mode held.
      base = cyc;
      push(base + 35, pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 43, pk(2'd1, 2'd0, 1'b1, 3'b000));
      push(base + 49, pk(2'd2, 2'd0, 1'b0, 3'b000));
      push(base + 57, pk(2'd2, 2'd0, 1'b1, 3'b000));
      push(base + 63, pk(2'd2, 2'd1, 1'b0, 3'b000));
      push(base + 71, pk(2'd2, 2'd1, 1'b1, 3'b000));
      push(base + 77, pk(2'd2, 2'd2, 1'b0, 3'b000));
      push(base + 81, 8'h00);
      press(3'b010, 5);
      wait_until(base + 14); press(3'b100, 5);
      wait_until(base + 28); press(3'b001, 5);
      wait_until(base + 42); press(3'b001, 5);
      wait_until(base + 56); press(3'b010, 5);
      wait_until(base + 70); press(3'b010, 5);
      wait_until(base + 80); do_reset(1'b1);

      // Mode button held through reset release is seen as a fresh press.
      base = cyc;
      push(base + 7,  pk(2'd1, 2'd0, 1'b0, 3'b000));
      push(base + 15, pk(2'd1, 2'd0, 1'b1, 3'b000));
      repeat (6) @(negedge clk);
      bus.i_sw_mode = 1'b0;
      wait_until(base + 18);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d expected events outstanding, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
